// File: rtl/mlp_neuron_seq.sv
// rtl/mlp_neuron_seq.sv - job sequencer for the signed 4x4 MAC neuron with ReLU output
module mlp_neuron_seq #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [15:0]      cfg_bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_i,
  input  logic [3:0]       in_w,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_total,
  output logic [15:0]      res_relu,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [1:0]        state;
  logic [15:0]       acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len;

  logic signed [7:0] i_ext;
  logic signed [7:0] w_ext;
  logic signed [7:0] prod;
  logic [15:0]       acc_next;
  logic [15:0]       relu_next;
  logic              last_term;

  assign i_ext = {{4{in_i[3]}}, in_i};
  assign w_ext = {{4{in_w[3]}}, in_w};
  assign prod  = i_ext * w_ext;

  // Bit 15 of the running total is dropped and bit 14 re-extended before each add
  assign acc_next  = {acc[14], acc[14:0]} + {{8{prod[7]}}, prod};
  assign relu_next = (!acc_next[15] && (acc_next != 16'h0000)) ? acc_next : 16'h0000;

  // len of 0 wraps to all-ones here, which is exactly the 2^LEN_W-term job
  assign last_term = (cnt == (len - ONE));

  assign in_ready  = (state == S_ACCUM);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= 16'h0000;
      cnt       <= '0;
      len       <= '0;
      res_total <= 16'h0000;
      res_relu  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            acc   <= cfg_bias;
            cnt   <= '0;
            len   <= cfg_len;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + ONE;
            if (last_term) begin
              state     <= S_DONE;
              res_total <= acc_next;
              res_relu  <= relu_next;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
